// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the sysid ID and timestamp words and checks them
// against expected values. Define SYSID_CHECKER_AUTOSTART_EN to run one check automatically after reset.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1316077507,
    parameter int          TIMEOUT_CYCLES     = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);
    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        addr_n, rd_n, busy_n, done_n, pass_n, to_n, go, expire;
    logic [31:0] id_n, ts_n;
`ifdef SYSID_CHECKER_AUTOSTART_EN
    logic auto_arm, auto_go;
    // one-shot implicit start: armed by reset, fires once on the second cycle after reset releases
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_arm <= 1'b1;
            auto_go  <= 1'b0;
        end else begin
            auto_go  <= auto_arm;
            auto_arm <= 1'b0;
        end
    end
    assign go = start | auto_go;
`else
    assign go = start;
`endif
    // a read in RD_ID/RD_TS aborts once it has stalled TIMEOUT_CYCLES consecutive cycles
    assign expire = avm_waitrequest && cnt == LIMIT;
    // next-state and next-output logic; every output is registered from these
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = avm_address;
        rd_n    = avm_read;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        to_n    = timeout_err;
        id_n    = id_value;
        ts_n    = timestamp_value;
        case (state)
            IDLE, DONE: if (go) begin
                state_n = RD_ID;
                cnt_n   = '0;
                addr_n  = 1'b0;
                rd_n    = 1'b1;
                busy_n  = 1'b1;
                done_n  = 1'b0;
                pass_n  = 1'b0;
                to_n    = 1'b0;
            end
            RD_ID, RD_TS: if (!avm_waitrequest) begin
                cnt_n   = '0;
                state_n = state == RD_ID ? RD_TS : CHECK;
                addr_n  = state == RD_ID;
                rd_n    = state == RD_ID;
                id_n    = state == RD_ID ? avm_readdata : id_value;
                ts_n    = state == RD_TS ? avm_readdata : timestamp_value;
            end else if (expire) begin
                state_n = DONE;
                cnt_n   = '0;
                addr_n  = 1'b0;
                rd_n    = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                pass_n  = 1'b0;
                to_n    = 1'b1;
            end else begin
                cnt_n = cnt + 16'd1;
            end
            CHECK: begin
                state_n = DONE;
                pass_n  = id_value == EXPECTED_ID && timestamp_value == EXPECTED_TIMESTAMP;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and output registers with synchronous reset to all-zero outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            avm_address     <= 1'b0;
            avm_read        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout_err     <= 1'b0;
            id_value        <= '0;
            timestamp_value <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            avm_address     <= addr_n;
            avm_read        <= rd_n;
            busy            <= busy_n;
            done            <= done_n;
            pass            <= pass_n;
            timeout_err     <= to_n;
            id_value        <= id_n;
            timestamp_value <= ts_n;
        end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: scoreboard bench for sysid_checker driving a programmable-stall sysid slave model
module tb_sysid_checker;
    localparam logic [31:0] GOOD_TS = 32'd1316077507;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest, busy, done, pass, timeout_err;
    logic [31:0] avm_readdata, id_value, timestamp_value;
    logic [31:0] slv_id = 32'd0, slv_ts = GOOD_TS;
    int          wid = 0, wts = 0, scnt = 0, cyc = 0, tests = 0, fails = 0;

    typedef struct {
        int          cyc;
        logic        p;
        logic        t;
        logic [31:0] id;
        logic [31:0] ts;
    } exp_t;
    exp_t q[$];
    exp_t e;

    sysid_checker #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
        .id_value(id_value), .timestamp_value(timestamp_value)
    );

    always #5 clock = ~clock;

    // slave: stalls the current read for wid/wts cycles, then returns the word for the address
    assign avm_waitrequest = avm_read && (scnt < (avm_address ? wts : wid));
    assign avm_readdata    = avm_address ? slv_ts : slv_id;
    always @(posedge clock) scnt <= (avm_read && avm_waitrequest) ? scnt + 1 : 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on each rising done and checks bus protocol every cycle
    logic done_q = 1'b0, prd = 1'b0, padr = 1'b0, pwait = 1'b0, prst = 1'b1;
    always @(negedge clock) begin
        if (done === 1'b1 && done_q !== 1'b1) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("pass", pass, e.p);
                chk("timeout_err", timeout_err, e.t);
                chk("id_value", id_value, e.id);
                chk("timestamp_value", timestamp_value, e.ts);
                chk("busy_at_done", busy, 0);
            end
        end
        if (avm_read === 1'b0) chk("addr_when_idle", avm_address, 0);
        if (prd && pwait && !prst && !timeout_err) begin
            chk("stall_hold_read", avm_read, 1);
            chk("stall_hold_addr", avm_address, padr);
        end
        done_q = done;
        prd    = avm_read;
        padr   = avm_address;
        pwait  = avm_waitrequest;
        prst   = reset;
    end

    task automatic issue(input int lat, input logic p, input logic t, input logic [31:0] eid, input logic [31:0] ets);
        @(posedge clock); #1;
        start = 1'b1;
        q.push_back('{cyc + lat, p, t, eid, ets});
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(done === 1'b1 && busy === 1'b0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(n < 100), 1);
        @(posedge clock); #1;
    endtask

    task automatic chk_zero();
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_id", id_value, 0);
        chk("rst_ts", timestamp_value, 0);
    endtask

    task automatic release_reset();
        @(posedge clock); #1;
        reset = 1'b0;
`ifdef SYSID_CHECKER_AUTOSTART_EN
        q.push_back('{cyc + 5, 1'b1, 1'b0, 32'd0, GOOD_TS});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_zero();
        release_reset();
`ifdef SYSID_CHECKER_AUTOSTART_EN
        @(negedge clock); chk("auto_rd_c0", avm_read, 0);
        @(negedge clock); chk("auto_rd_c1", avm_read, 0);
        @(negedge clock); chk("auto_rd_c2", avm_read, 1);
        wait_done("auto_done");
`else
        seen = 1'b0;
        repeat (100) begin
            @(negedge clock);
            seen |= avm_read;
        end
        chk("no_bus_activity", seen, 0);
        @(posedge clock); #1;
`endif
        // healthy zero-wait sequence with back-to-back reads
        issue(4, 1'b1, 1'b0, 32'd0, GOOD_TS);
        @(negedge clock); chk("t1_rd_id", {avm_read, avm_address}, 2'b10);
        @(negedge clock); chk("t1_rd_ts", {avm_read, avm_address}, 2'b11);
        @(negedge clock); chk("t1_check", avm_read, 0);
        wait_done("t1_done");
        // timestamp mismatch
        slv_ts = 32'h4E71A3C4;
        issue(4, 1'b0, 1'b0, 32'd0, 32'h4E71A3C4);
        wait_done("t2_done");
        // ID mismatch
        slv_id = 32'd5; slv_ts = GOOD_TS;
        issue(4, 1'b0, 1'b0, 32'd5, GOOD_TS);
        wait_done("t3_done");
        // stalled slave: 5 cycles on ID, 3 on timestamp
        slv_id = 32'd0; wid = 5; wts = 3;
        issue(12, 1'b1, 1'b0, 32'd0, GOOD_TS);
        wait_done("t4_done");
        // timestamp read stuck: abort after 8 stalled cycles, timestamp_value untouched
        wid = 0; wts = 1000; slv_ts = 32'hDEADBEEF;
        issue(10, 1'b0, 1'b1, 32'd0, GOOD_TS);
        wait_done("t5_done");
        // healthy rerun clears the timeout
        wts = 0; slv_ts = GOOD_TS;
        issue(4, 1'b1, 1'b0, 32'd0, GOOD_TS);
        wait_done("t6_done");
        // extra start during RD_TS must be ignored
        wts = 3;
        issue(7, 1'b1, 1'b0, 32'd0, GOOD_TS);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done("t7_done");
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("t7_done_held", done, 1);
        chk("t7_not_busy", busy, 0);
        // reset during a stalled ID read
        wts = 0; wid = 1000;
        @(posedge clock); #1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("t8_stalled_read", {avm_read, avm_waitrequest}, 2'b11);
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk_zero();
        wid = 0;
        release_reset();
`ifdef SYSID_CHECKER_AUTOSTART_EN
        wait_done("t8_auto_done");
`else
        repeat (10) @(negedge clock);
        chk("t8_stays_idle", {avm_read, busy, done}, 3'b000);
`endif
        repeat (3) @(posedge clock);
        chk("queue_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
